wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter and register scoreboard for the 32x32 register file. Two result producers, the single-cycle ALU path (port 0) and the long-latency load/multi-cycle path (port 1), compete for the register file's single write port (RegWrite / rd / write_data3). A valid/ready handshake with round-robin arbitration resolves the contention. The block holds a one-entry registered output stage and a 32-bit busy scoreboard that decode uses to detect pending destinations.

## Interface
Parameters:
- A_WIDTH, 5, register address width
- D_WIDTH, 32, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- req0_valid  in  1  ALU result valid
- req0_rd  in  A_WIDTH  ALU destination register
- req0_data  in  D_WIDTH  ALU result
- req0_ready  out  1  ALU result accepted this cycle
- req1_valid / req1_rd / req1_data / req1_ready  same as port 0, load/long-latency path
- wb_stall  in  1  freeze the write port; hold the pending write
- mark_valid  in  1  decode issued an instruction with a destination
- mark_rd  in  A_WIDTH  destination to mark busy
- RegWrite  out  1  register-file write enable
- rd  out  A_WIDTH  register-file write address
- write_data3  out  D_WIDTH  register-file write data
- busy  out  2**A_WIDTH  per-register pending-write flags; bit 0 always 0

## Operation
- Output stage: stage_valid, stage_rd, stage_data registers.
- RegWrite = stage_valid && !wb_stall && stage_rd != 0. rd and write_data3 are driven directly from the stage registers.
- The stage drains on any cycle with stage_valid && !wb_stall. An entry with rd=0 drains without asserting RegWrite.
- can_load = !stage_valid || (stage_valid && !wb_stall).
- Arbitration: round-robin between 2 requesters, priority pointer prio (0 or 1).
  - Both valid: grant = prio.
  - One valid: grant = that port.
  - After any acceptance, prio = ~grant.
  - No acceptance: prio holds.
- reqN_ready = can_load && grant==N && reqN_valid. At most one ready per cycle. Ready depends combinationally on valids and state. Both readies are 0 while rst_n is low.
- Accept (valid && ready) loads the stage with the requester's rd/data. The stage_valid next state is 1 on accept; otherwise 0 if draining, otherwise unchanged.
- A requester must hold valid/rd/data stable until ready.
- Scoreboard:
  - mark_valid sets busy[mark_rd] at the edge, unless mark_rd = 0.
  - A drain with stage_rd != 0 clears busy[stage_rd].
  - Simultaneous set and clear of the same index: set wins, because the new producer owns the register.
  - Set and clear of different indices both apply.
- wb_stall: the stage holds, RegWrite = 0, no acceptance if the stage is full. If the stage is empty, one result is still accepted and is then held.

## Timing
- Reset values:
  - RegWrite 0, rd 0, write_data3 0
  - stage_valid 0, prio 0
  - busy all 0
- Latency: accept at edge N produces RegWrite high in cycle N..N+1. The regfile captures the write at edge N+1, and busy clears at edge N+1.
- Throughput: one write per cycle with wb_stall low. Back-to-back accepts are allowed, since the stage loads while draining.
- Reset asserted mid-operation: the pending stage entry and all busy bits are discarded immediately (async). No RegWrite is produced after rst_n falls.
- busy is registered; a mark at edge N is visible from cycle N onward.

## Structure
- Shared package wb_pkg:
  - localparams XLEN=32 and REG_AW=5
  - typedef wb_req_t struct {valid, rd, data}
  - NUM_REGS constant
- Sub-module rr_arb2: two-request round-robin arbiter.
  - Inputs: clk, rst_n, req[1:0], advance.
  - Output: one-hot grant[1:0].
  - Holds the prio flop internally.
- Top level holds the output stage, the scoreboard and the handshake glue.

## Test plan
- Single write: req0 {rd=5, data=0xDEADBEEF} for one cycle, stall low → req0_ready=1 same cycle. Next cycle RegWrite=1, rd=5, write_data3=0xDEADBEEF; then RegWrite=0.
- Contention: both valid continuously, req0 rd=1 and req1 rd=2 → grants alternate 0,1,0,1. RegWrite is high every cycle with rd 1,2,1,2.
- Stall: load the stage with rd=7, data=0x11, then raise wb_stall for 3 cycles with req1 valid.
  - RegWrite=0 and req1_ready=0 throughout; rd=7 is held.
  - On release, write 0x11 to r7, and req1 is accepted the same cycle.
- rd=0 write: req1 {rd=0, data=0xFFFF} → accepted, RegWrite stays 0, busy[0] stays 0.
- Scoreboard collision: busy[3]=1 with a pending write to r3 drains while mark_valid/mark_rd=3 in the same cycle → busy[3] stays 1. Without the mark, busy[3]=0 after the edge.
- Reset mid-stall: with the stage full, drop rst_n → RegWrite, rd, write_data3 and busy go to 0 immediately, and no write occurs after release.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared widths and the write-back request record used by the arbiter and its bench.
package wb_pkg;
    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 1 << REG_AW;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Producer handshakes, decode mark port and register-file write port of the arbiter.
interface wb_arbiter_if #(
    parameter int A_WIDTH = wb_pkg::REG_AW,
    parameter int D_WIDTH = wb_pkg::XLEN
) ();
    logic                  req0_valid;
    logic [A_WIDTH-1:0]    req0_rd;
    logic [D_WIDTH-1:0]    req0_data;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [A_WIDTH-1:0]    req1_rd;
    logic [D_WIDTH-1:0]    req1_data;
    logic                  req1_ready;
    logic                  wb_stall;
    logic                  mark_valid;
    logic [A_WIDTH-1:0]    mark_rd;
    logic                  RegWrite;
    logic [A_WIDTH-1:0]    rd;
    logic [D_WIDTH-1:0]    write_data3;
    logic [2**A_WIDTH-1:0] busy;

    modport slave (
        input  req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
        input  wb_stall, mark_valid, mark_rd,
        output req0_ready, req1_ready, RegWrite, rd, write_data3, busy
    );

    modport master (
        output req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
        output wb_stall, mark_valid, mark_rd,
        input  req0_ready, req1_ready, RegWrite, rd, write_data3, busy
    );
endinterface

// File: rtl/wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer flips away from the winner on each advance.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic prio_q, prio_d;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
        prio_d = prio_q;
        // Winner 0 hands priority to 1 and vice versa.
        if (advance) prio_d = grant[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prio_q <= 1'b0;
        else        prio_q <= prio_d;
    end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin handshake into a one-entry stage feeding the
// register-file write port, plus the per-register busy scoreboard for decode.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int A_WIDTH = REG_AW,
    parameter int D_WIDTH = XLEN
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_arbiter_if.slave   bus
);
    localparam int NREGS = 2 ** A_WIDTH;

    typedef struct packed {
        logic               valid;
        logic [A_WIDTH-1:0] rd;
        logic [D_WIDTH-1:0] data;
    } stage_t;

    stage_t             stage_q, stage_d;
    logic [NREGS-1:0]   busy_q, busy_d;
    logic [1:0]         req_vec, grant;
    logic               drain, can_load, rdy0, rdy1, accept;

    assign drain    = stage_q.valid && !bus.wb_stall;
    assign can_load = !stage_q.valid || drain;
    assign req_vec  = {bus.req1_valid, bus.req0_valid};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_vec),
        .advance (accept),
        .grant   (grant)
    );

    assign rdy0   = rst_n && can_load && grant[0] && bus.req0_valid;
    assign rdy1   = rst_n && can_load && grant[1] && bus.req1_valid;
    assign accept = rdy0 || rdy1;

    assign bus.req0_ready  = rdy0;
    assign bus.req1_ready  = rdy1;
    assign bus.RegWrite    = drain && (stage_q.rd != '0);
    assign bus.rd          = stage_q.rd;
    assign bus.write_data3 = stage_q.data;
    assign bus.busy        = busy_q;

    always_comb begin
        stage_d = stage_q;
        if (rdy0)       stage_d = '{valid: 1'b1, rd: bus.req0_rd, data: bus.req0_data};
        else if (rdy1)  stage_d = '{valid: 1'b1, rd: bus.req1_rd, data: bus.req1_data};
        else if (drain) stage_d.valid = 1'b0;
    end

    // A new mark beats the drain of the same register: the new producer owns it.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_d[gi] = 1'b0;
            end else begin : g_reg
                logic set_hit, clr_hit;
                assign set_hit    = bus.mark_valid && (bus.mark_rd == A_WIDTH'(gi));
                assign clr_hit    = drain && (stage_q.rd == A_WIDTH'(gi));
                assign busy_d[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : busy_q[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
            busy_q  <= '0;
        end else begin
            stage_q <= stage_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a scoreboard of expected register-file writes.
module tb_wb_arbiter;
    import wb_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_prio;
    logic g;
    wb_req_t exp_q[$];
    wb_req_t e;

    wb_arbiter_if #(.A_WIDTH(REG_AW), .D_WIDTH(XLEN)) bus ();

    wb_arbiter #(.A_WIDTH(REG_AW), .D_WIDTH(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push(input logic [REG_AW-1:0] r, input logic [XLEN-1:0] d);
        exp_q.push_back('{valid: 1'b1, rd: r, data: d});
    endtask

    // Every register-file write must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (bus.RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL wb_unexpected: observed write rd=%0d data=%0h expected no write",
                       bus.rd, bus.write_data3);
            end else begin
                e = exp_q.pop_front();
                chk("wb_rd", 64'(bus.rd), 64'(e.rd));
                chk("wb_data", 64'(bus.write_data3), 64'(e.data));
                $display("write rd=%0d data=%0h", bus.rd, bus.write_data3);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_rd = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_rd = '0; bus.req1_data = '0;
        bus.wb_stall = 1'b0; bus.mark_valid = 1'b0; bus.mark_rd = '0;
        exp_prio = 1'b0;

        // Reset state; readies stay low during reset even with requests present.
        #2;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("rst_ready0", 64'(bus.req0_ready), 0);
        chk("rst_ready1", 64'(bus.req1_ready), 0);
        chk("rst_regwrite", 64'(bus.RegWrite), 0);
        chk("rst_rd", 64'(bus.rd), 0);
        chk("rst_wdata", 64'(bus.write_data3), 0);
        chk("rst_busy", 64'(bus.busy), 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single write with a mark on the same destination.
        tick();
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd5; bus.req0_data = 32'hDEADBEEF;
        bus.mark_valid = 1'b1; bus.mark_rd = 5'd5;
        mid();
        chk("t1_ready0", 64'(bus.req0_ready), 1);
        chk("t1_ready1", 64'(bus.req1_ready), 0);
        push(5'd5, 32'hDEADBEEF);
        exp_prio = 1'b1;
        tick();
        bus.req0_valid = 1'b0; bus.mark_valid = 1'b0;
        mid();
        chk("t1_regwrite", 64'(bus.RegWrite), 1);
        chk("t1_busy5_set", 64'(bus.busy[5]), 1);
        tick();
        mid();
        chk("t1_idle", 64'(bus.RegWrite), 0);
        chk("t1_busy5_clr", 64'(bus.busy[5]), 0);

        // Contention: grants alternate from the current priority pointer.
        tick();
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd1; bus.req0_data = 32'h1001;
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd2; bus.req1_data = 32'h2002;
        for (int i = 0; i < 4; i++) begin
            mid();
            g = exp_prio;
            chk("t2_ready0", 64'(bus.req0_ready), 64'(!g));
            chk("t2_ready1", 64'(bus.req1_ready), 64'(g));
            if (i > 0) chk("t2_regwrite", 64'(bus.RegWrite), 1);
            if (g) push(5'd2, 32'h2002);
            else   push(5'd1, 32'h1001);
            exp_prio = !g;
            tick();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        mid();
        tick();

        // Stall with a full stage: nothing writes, nothing is accepted.
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd7; bus.req0_data = 32'h11;
        mid();
        chk("t3_ready0", 64'(bus.req0_ready), 1);
        push(5'd7, 32'h11);
        exp_prio = 1'b1;
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd9; bus.req1_data = 32'h99;
        bus.wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("t3_stall_regwrite", 64'(bus.RegWrite), 0);
            chk("t3_stall_ready1", 64'(bus.req1_ready), 0);
            chk("t3_stall_rd", 64'(bus.rd), 7);
            tick();
        end
        bus.wb_stall = 1'b0;
        mid();
        chk("t3_release_ready1", 64'(bus.req1_ready), 1);
        chk("t3_release_regwrite", 64'(bus.RegWrite), 1);
        push(5'd9, 32'h99);
        exp_prio = 1'b0;
        tick();
        bus.req1_valid = 1'b0;
        mid();
        tick();

        // Stall with an empty stage still accepts one result and holds it.
        bus.wb_stall = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd4; bus.req0_data = 32'h44;
        mid();
        chk("t3e_ready0", 64'(bus.req0_ready), 1);
        push(5'd4, 32'h44);
        exp_prio = 1'b1;
        tick();
        bus.req0_valid = 1'b0;
        mid();
        chk("t3e_held_regwrite", 64'(bus.RegWrite), 0);
        chk("t3e_held_rd", 64'(bus.rd), 4);
        tick();
        bus.wb_stall = 1'b0;
        mid();
        chk("t3e_release_regwrite", 64'(bus.RegWrite), 1);
        tick();

        // Write to r0 drains silently; a mark of r0 is ignored.
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd0; bus.req1_data = 32'hFFFF;
        bus.mark_valid = 1'b1; bus.mark_rd = 5'd0;
        mid();
        chk("t4_ready1", 64'(bus.req1_ready), 1);
        exp_prio = 1'b0;
        tick();
        bus.req1_valid = 1'b0; bus.mark_valid = 1'b0;
        mid();
        chk("t4_regwrite", 64'(bus.RegWrite), 0);
        chk("t4_busy0", 64'(bus.busy[0]), 0);
        tick();

        // Scoreboard: set beats clear on the same index, different indices both apply.
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd3; bus.req0_data = 32'h33;
        bus.mark_valid = 1'b1; bus.mark_rd = 5'd3;
        mid();
        chk("t5_ready0", 64'(bus.req0_ready), 1);
        push(5'd3, 32'h33);
        exp_prio = 1'b1;
        tick();
        bus.req0_valid = 1'b0;
        mid();
        chk("t5_busy3_pending", 64'(bus.busy[3]), 1);
        chk("t5_regwrite", 64'(bus.RegWrite), 1);
        tick();
        bus.mark_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd3; bus.req0_data = 32'h34;
        mid();
        chk("t5_busy3_set_wins", 64'(bus.busy[3]), 1);
        chk("t5_ready0_b", 64'(bus.req0_ready), 1);
        push(5'd3, 32'h34);
        tick();
        bus.req0_valid = 1'b0;
        bus.mark_valid = 1'b1; bus.mark_rd = 5'd6;
        mid();
        chk("t5_busy3_before_clr", 64'(bus.busy[3]), 1);
        chk("t5_regwrite_b", 64'(bus.RegWrite), 1);
        tick();
        bus.mark_valid = 1'b0;
        mid();
        chk("t5_busy3_cleared", 64'(bus.busy[3]), 0);
        chk("t5_busy6_set", 64'(bus.busy[6]), 1);
        tick();

        // Reset while a write is held under stall discards it immediately.
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd10; bus.req0_data = 32'hAA;
        bus.mark_valid = 1'b1; bus.mark_rd = 5'd10;
        mid();
        chk("t6_ready0", 64'(bus.req0_ready), 1);
        push(5'd10, 32'hAA);
        tick();
        bus.req0_valid = 1'b0; bus.mark_valid = 1'b0;
        bus.wb_stall = 1'b1;
        mid();
        chk("t6_stall_regwrite", 64'(bus.RegWrite), 0);
        chk("t6_stall_rd", 64'(bus.rd), 10);
        chk("t6_busy10", 64'(bus.busy[10]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_regwrite", 64'(bus.RegWrite), 0);
        chk("t6_rst_rd", 64'(bus.rd), 0);
        chk("t6_rst_wdata", 64'(bus.write_data3), 0);
        chk("t6_rst_busy", 64'(bus.busy), 0);
        void'(exp_q.pop_back());
        tick();
        bus.wb_stall = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("t6_post_regwrite", 64'(bus.RegWrite), 0);
            tick();
        end

        chk("final_queue_empty", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
